se_ifetch: RTL and testbench

SE_IFETCH -- requirements
Module: se_ifetch

---
 rtl/se_ifetch.sv | 112 +++++++++++
 tb/tb_se_ifetch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/se_ifetch.sv
// Single-issue instruction fetch stage. It issues one memory request at a time and presents
// each fetched word to decode through a valid/ready hold register.
module se_ifetch #(
  parameter int               XLEN = 64,
  parameter int               ILEN = 32,
  parameter logic [ILEN-1:0]  NOP  = 32'h0000_0013
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic             pc_en_o,
  input  logic             flush_i,
  output logic             imem_req_o,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [ILEN-1:0]  imem_rdata_i,
  output logic             if_valid_o,
  input  logic             if_ready_i,
  output logic [ILEN-1:0]  if_instr_o,
  output logic [XLEN-1:0]  if_pc_o,
  output logic             if_misalign_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t state, state_nx;
  logic   discard, discard_nx;
  logic   req, pc_en, valid;
  logic   load_pc, load_nop, load_data;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx   = state;
    discard_nx = discard;
    req        = 1'b0;
    pc_en      = 1'b0;
    valid      = 1'b0;
    load_pc    = 1'b0;
    load_nop   = 1'b0;
    load_data  = 1'b0;
    unique case (state)
      S_IDLE: state_nx = S_REQ;
      S_REQ: begin
        if (!flush_i) begin
          if (pc_i[1:0] != 2'b00) begin
            load_nop = 1'b1;
            state_nx = S_HOLD;
          end else begin
            req = 1'b1;
            if (imem_gnt_i) begin
              pc_en    = 1'b1;
              load_pc  = 1'b1;
              state_nx = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        // A response arriving under a flush, or owed to an earlier flush, is dropped.
        if (imem_rvalid_i) begin
          if (discard || flush_i) begin
            discard_nx = 1'b0;
            state_nx   = S_REQ;
          end else begin
            load_data = 1'b1;
            state_nx  = S_HOLD;
          end
        end else if (flush_i) begin
          discard_nx = 1'b1;
        end
      end
      S_HOLD: begin
        // Flush wins over a same-cycle ready, so the word is withdrawn rather than handed over.
        valid = !flush_i;
        if (flush_i || if_ready_i) state_nx = S_REQ;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      discard       <= 1'b0;
      if_instr_o    <= '0;
      if_pc_o       <= '0;
      if_misalign_o <= 1'b0;
    end else begin
      state   <= state_nx;
      discard <= discard_nx;
      if (load_pc) if_pc_o <= pc_i;
      if (load_nop) begin
        if_pc_o       <= pc_i;
        if_instr_o    <= NOP;
        if_misalign_o <= 1'b1;
      end
      if (load_data) begin
        if_instr_o    <= imem_rdata_i;
        if_misalign_o <= 1'b0;
      end
    end
  end

  // Handshake strobes are held low while reset is asserted, whatever state the register still holds.
  assign imem_req_o  = req   & ~rst_i;
  assign pc_en_o     = pc_en & ~rst_i;
  assign if_valid_o  = valid & ~rst_i;
  assign imem_addr_o = pc_i;

endmodule

// File: tb/tb_se_ifetch.sv
// Testbench for se_ifetch: directed scenarios, then a randomized run checked by a scoreboard
// against a memory / PC-register / decode-sink model.
module tb_se_ifetch;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [XLEN-1:0]  pc_i;
  logic             pc_en_o;
  logic             flush_i;
  logic             imem_req_o;
  logic [XLEN-1:0]  imem_addr_o;
  logic             imem_gnt_i;
  logic             imem_rvalid_i;
  logic [ILEN-1:0]  imem_rdata_i;
  logic             if_valid_o;
  logic             if_ready_i;
  logic [ILEN-1:0]  if_instr_o;
  logic [XLEN-1:0]  if_pc_o;
  logic             if_misalign_o;

  se_ifetch dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .pc_en_o(pc_en_o), .flush_i(flush_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .if_valid_o(if_valid_o),
    .if_ready_i(if_ready_i), .if_instr_o(if_instr_o), .if_pc_o(if_pc_o),
    .if_misalign_o(if_misalign_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_xfer   = 0;
  bit   rand_phase = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic settle();
    #1;
  endtask

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [ILEN-1:0] mem_word(input logic [XLEN-1:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  // Scoreboard monitor: every accepted transfer must match the oldest expected word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (rand_phase && if_valid_o && if_ready_i) begin
        n_xfer++;
        if (sb.size() == 0) begin
          check("sb_nonempty", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check("rnd_instr", 64'(if_instr_o), 64'(e.instr));
          check("rnd_pc", if_pc_o, e.pc);
          check("rnd_misalign", 64'(if_misalign_o), 64'd0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] out_addr;
    bit              outstanding, was_out, adv;
    int              cd;
    int              pulses;

    rst_i = 1'b1; flush_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    imem_rdata_i = '0; if_ready_i = 1'b0; pc_i = 64'h1000;
    cyc(); cyc(); cyc(); settle();
    check("rst_req", 64'(imem_req_o), 64'd0);
    check("rst_pc_en", 64'(pc_en_o), 64'd0);
    check("rst_valid", 64'(if_valid_o), 64'd0);
    check("rst_instr", 64'(if_instr_o), 64'd0);
    check("rst_pc", if_pc_o, 64'd0);
    check("rst_misalign", 64'(if_misalign_o), 64'd0);

    // First cycle after release: still idle.
    cyc(); rst_i = 1'b0; settle();
    check("post_rst_req", 64'(imem_req_o), 64'd0);
    check("post_rst_pc_en", 64'(pc_en_o), 64'd0);
    check("post_rst_valid", 64'(if_valid_o), 64'd0);

    // Basic fetch: immediate grant, rvalid next cycle, ready immediately.
    cyc(); imem_gnt_i = 1'b1; if_ready_i = 1'b1; settle();
    check("f1_req", 64'(imem_req_o), 64'd1);
    check("f1_addr", imem_addr_o, 64'h1000);
    check("f1_pc_en", 64'(pc_en_o), 64'd1);
    cyc(); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0050_0093; settle();
    check("f1_wait_valid", 64'(if_valid_o), 64'd0);
    check("f1_wait_pc_en", 64'(pc_en_o), 64'd0);
    check("f1_wait_req", 64'(imem_req_o), 64'd0);
    cyc(); imem_rvalid_i = 1'b0; settle();
    check("f1_valid", 64'(if_valid_o), 64'd1);
    check("f1_instr", 64'(if_instr_o), 64'h0050_0093);
    check("f1_pc", if_pc_o, 64'h1000);
    check("f1_misalign", 64'(if_misalign_o), 64'd0);
    pc_i = 64'h1004;

    // Grant withheld for 3 cycles: request stays stable, one pc_en pulse on the grant cycle.
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(); if_ready_i = 1'b0; imem_gnt_i = (i == 3); settle();
      check("stall_req", 64'(imem_req_o), 64'd1);
      check("stall_addr", imem_addr_o, 64'h1004);
      check("stall_pc_en", 64'(pc_en_o), 64'(i == 3));
      pulses += int'(pc_en_o);
    end
    check("stall_pulses", 64'(pulses), 64'd1);
    cyc(); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h00A0_0113;
    cyc(); imem_rvalid_i = 1'b0;

    // Decode back-pressure for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      settle();
      check("bp_valid", 64'(if_valid_o), 64'd1);
      check("bp_instr", 64'(if_instr_o), 64'h00A0_0113);
      check("bp_pc", if_pc_o, 64'h1004);
      check("bp_req", 64'(imem_req_o), 64'd0);
      cyc();
    end
    if_ready_i = 1'b1; settle();
    check("bp_release_valid", 64'(if_valid_o), 64'd1);

    // Flush in REQ suppresses the request and the PC advance.
    cyc(); if_ready_i = 1'b0; flush_i = 1'b1; imem_gnt_i = 1'b1; pc_i = 64'h2000; settle();
    check("flreq_req", 64'(imem_req_o), 64'd0);
    check("flreq_pc_en", 64'(pc_en_o), 64'd0);
    cyc(); flush_i = 1'b0; settle();
    check("flreq_then_req", 64'(imem_req_o), 64'd1);
    check("flreq_then_pc_en", 64'(pc_en_o), 64'd1);

    // Flush twice in WAIT, stale data two cycles later must be dropped exactly once.
    cyc(); imem_gnt_i = 1'b0; flush_i = 1'b1; pc_i = 64'h3000; settle();
    check("flwait_pc_en", 64'(pc_en_o), 64'd0);
    cyc(); settle();
    check("flwait_valid", 64'(if_valid_o), 64'd0);
    cyc(); flush_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; settle();
    check("drop_valid", 64'(if_valid_o), 64'd0);
    cyc(); imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1; settle();
    check("redir_valid", 64'(if_valid_o), 64'd0);
    check("redir_req", 64'(imem_req_o), 64'd1);
    check("redir_addr", imem_addr_o, 64'h3000);
    check("redir_instr_kept", 64'(if_instr_o), 64'h00A0_0113);
    cyc(); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h02A0_0193;
    cyc(); imem_rvalid_i = 1'b0; settle();
    check("redir_fetch_valid", 64'(if_valid_o), 64'd1);
    check("redir_fetch_instr", 64'(if_instr_o), 64'h02A0_0193);
    check("redir_fetch_pc", if_pc_o, 64'h3000);

    // Flush with ready in HOLD: no transfer, back to REQ (misaligned PC there).
    flush_i = 1'b1; if_ready_i = 1'b1; settle();
    check("flhold_valid", 64'(if_valid_o), 64'd0);
    cyc(); flush_i = 1'b0; if_ready_i = 1'b0; imem_gnt_i = 1'b1; pc_i = 64'h1002; settle();
    check("mis_req", 64'(imem_req_o), 64'd0);
    check("mis_pc_en", 64'(pc_en_o), 64'd0);
    check("mis_not_valid", 64'(if_valid_o), 64'd0);
    cyc(); imem_gnt_i = 1'b0; settle();
    check("mis_valid", 64'(if_valid_o), 64'd1);
    check("mis_flag", 64'(if_misalign_o), 64'd1);
    check("mis_instr", 64'(if_instr_o), 64'h0000_0013);
    check("mis_pc", if_pc_o, 64'h1002);
    check("mis_hold_req", 64'(imem_req_o), 64'd0);
    if_ready_i = 1'b1;
    cyc(); if_ready_i = 1'b0; pc_i = 64'h4000; imem_gnt_i = 1'b1; settle();
    check("pre_rst_req", 64'(imem_req_o), 64'd1);

    // Reset in WAIT, stale rvalid right after release.
    cyc(); imem_gnt_i = 1'b0;
    cyc(); rst_i = 1'b1; settle();
    check("rstw_req", 64'(imem_req_o), 64'd0);
    check("rstw_pc_en", 64'(pc_en_o), 64'd0);
    check("rstw_valid", 64'(if_valid_o), 64'd0);
    cyc(); rst_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBADB_AD00; settle();
    check("stale_valid", 64'(if_valid_o), 64'd0);
    check("stale_req", 64'(imem_req_o), 64'd0);
    cyc(); imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1; if_ready_i = 1'b1; settle();
    check("fresh_req", 64'(imem_req_o), 64'd1);
    check("fresh_addr", imem_addr_o, 64'h4000);
    check("fresh_instr_cleared", 64'(if_instr_o), 64'd0);
    cyc(); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0513;
    cyc(); imem_rvalid_i = 1'b0; settle();
    check("fresh_valid", 64'(if_valid_o), 64'd1);
    check("fresh_instr", 64'(if_instr_o), 64'h0000_0513);
    check("fresh_pc", if_pc_o, 64'h4000);
    check("fresh_misalign", 64'(if_misalign_o), 64'd0);
    cyc(); if_ready_i = 1'b0; settle();

    // Randomized run: memory with random grant/latency and spurious rvalid, PC register, decode sink.
    pc_reg = {32'h0, $urandom()} & ~64'h3;
    outstanding = 1'b0; adv = 1'b0; cd = 0; out_addr = '0;
    rand_phase = 1'b1;
    for (int c = 0; c < 640; c++) begin
      cyc();
      if (adv) pc_reg += 64'd4;
      adv = 1'b0;
      pc_i = pc_reg;
      was_out = outstanding;
      imem_rvalid_i = 1'b0;
      if (outstanding) begin
        if (cd == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_word(out_addr);
          sb.push_back('{pc: out_addr, instr: mem_word(out_addr)});
          outstanding   = 1'b0;
        end else begin
          cd--;
        end
      end else if ($urandom_range(0, 5) == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD0_0000 | ($urandom() & 32'hFFFF);
      end
      imem_gnt_i = (c < 600) ? 1'($urandom_range(0, 1)) : 1'b0;
      if_ready_i = (c < 600) ? ($urandom_range(0, 2) != 0) : 1'b1;
      settle();
      if (was_out) check("one_outstanding", 64'(imem_req_o), 64'd0);
      check("pc_en_on_gnt", 64'(pc_en_o), 64'(imem_req_o && imem_gnt_i));
      if (imem_req_o && imem_gnt_i) begin
        check("rnd_addr", imem_addr_o, pc_reg);
        outstanding = 1'b1;
        out_addr    = pc_reg;
        cd          = $urandom_range(0, 3);
      end
      if (pc_en_o) adv = 1'b1;
    end
    cyc(); #3;
    rand_phase = 1'b0;
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("rnd_enough_xfers", 64'(n_xfer >= 20), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
